// File: rtl/wishbone_bus_if_pkg.sv
// Shared definitions for the core-to-Wishbone bridge: FSM state encoding,
// stall vector width, zero word and the registered Wishbone request bundle.
package wishbone_bus_if_pkg;

    localparam int          STALL_W_DEFAULT = 6;
    localparam logic [31:0] ZERO_WORD       = 32'h0000_0000;

    typedef enum logic [1:0] {
        WB_IDLE           = 2'd0,
        WB_BUSY           = 2'd1,
        WB_WAIT_FOR_STALL = 2'd2
    } wb_state_e;

    // Everything the bridge drives onto the Wishbone master side.
    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
        logic [3:0]  sel;
        logic        stb;
        logic        cyc;
    } wb_req_t;

    localparam wb_req_t WB_REQ_IDLE = '0;

endpackage

// File: rtl/wishbone_bus_if.sv
// Bridges a single-cycle core memory port to a classic Wishbone B3 master.
// A core access becomes a multi-cycle bus cycle while the pipeline is held
// via stallreq_o; read data is parked in rd_buf until ctrl releases stall_i.
module wishbone_bus_if
    import wishbone_bus_if_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int STALL_W        = STALL_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               cpu_ce_i,
    input  logic               cpu_we_i,
    input  logic [31:0]        cpu_addr_i,
    input  logic [3:0]         cpu_sel_i,
    input  logic [31:0]        cpu_data_i,
    output logic [31:0]        cpu_data_o,

    input  logic [STALL_W-1:0] stall_i,
    input  logic               flush_i,
    output logic               stallreq_o,
    output logic               err_o,

    output logic [31:0]        wb_adr_o,
    output logic [31:0]        wb_dat_o,
    input  logic [31:0]        wb_dat_i,
    output logic               wb_we_o,
    output logic [3:0]         wb_sel_o,
    output logic               wb_stb_o,
    output logic               wb_cyc_o,
    input  logic               wb_ack_i
);

    // Counter only needs to reach TIMEOUT_CYCLES-1; a timeout of 0 disables it.
    localparam bit          TO_EN     = (TIMEOUT_CYCLES != 0);
    localparam int          CNT_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int          CNT_MAX_I = TO_EN ? (TIMEOUT_CYCLES - 1) : 0;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_MAX_I[CNT_W-1:0];

    wb_state_e         state_q, state_d;
    wb_req_t           wb_q, wb_d;
    logic [31:0]       rd_buf_q, rd_buf_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              timeout_hit;
    logic              stall_active;

    assign stall_active = (stall_i != '0);

    // Abort only when the slave stays silent and no flush takes priority.
    assign timeout_hit = TO_EN && (state_q == WB_BUSY) && !flush_i && !wb_ack_i
                         && (cnt_q == CNT_MAX);

    // Next-state, next-bus-request and core-facing outputs.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path leaves one unassigned (no latches).
        state_d    = state_q;
        wb_d       = wb_q;
        rd_buf_d   = rd_buf_q;
        cnt_d      = cnt_q;
        err_d      = 1'b0;
        stallreq_o = 1'b0;
        cpu_data_o = ZERO_WORD;

        case (state_q)
            WB_IDLE: begin
                stallreq_o = cpu_ce_i & ~flush_i;
                if (cpu_ce_i && !flush_i) begin
                    wb_d = '{adr: cpu_addr_i, dat: cpu_data_i, we: cpu_we_i,
                             sel: cpu_sel_i, stb: 1'b1, cyc: 1'b1};
                    cnt_d   = '0;
                    state_d = WB_BUSY;
                end
            end

            WB_BUSY: begin
                if (flush_i) begin
                    // Flush beats a simultaneous ack; its data is thrown away.
                    stallreq_o = 1'b1;
                    wb_d       = WB_REQ_IDLE;
                    rd_buf_d   = ZERO_WORD;
                    state_d    = WB_IDLE;
                end else if (wb_ack_i) begin
                    stallreq_o = 1'b0;
                    cpu_data_o = cpu_we_i ? ZERO_WORD : wb_dat_i;
                    wb_d       = WB_REQ_IDLE;
                    if (!cpu_we_i) begin
                        rd_buf_d = wb_dat_i;
                    end
                    state_d = stall_active ? WB_WAIT_FOR_STALL : WB_IDLE;
                end else if (timeout_hit) begin
                    stallreq_o = 1'b0;
                    wb_d       = WB_REQ_IDLE;
                    rd_buf_d   = ZERO_WORD;
                    err_d      = 1'b1;
                    state_d    = stall_active ? WB_WAIT_FOR_STALL : WB_IDLE;
                end else begin
                    stallreq_o = 1'b1;
                    if (TO_EN && (cnt_q != CNT_MAX)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            WB_WAIT_FOR_STALL: begin
                // Another stage still stalls; keep presenting the captured data.
                cpu_data_o = rd_buf_q;
                if (!stall_active) begin
                    state_d = WB_IDLE;
                end
            end

            default: begin
                state_d = WB_IDLE;
                wb_d    = WB_REQ_IDLE;
            end
        endcase
    end

    // State, registered bus request, read buffer, timeout counter and error pulse.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (rst) begin
            state_q  <= WB_IDLE;
            wb_q     <= WB_REQ_IDLE;
            rd_buf_q <= ZERO_WORD;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wb_q     <= wb_d;
            rd_buf_q <= rd_buf_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    assign wb_adr_o = wb_q.adr;
    assign wb_dat_o = wb_q.dat;
    assign wb_we_o  = wb_q.we;
    assign wb_sel_o = wb_q.sel;
    assign wb_stb_o = wb_q.stb;
    assign wb_cyc_o = wb_q.cyc;
    assign err_o    = err_q;

endmodule

// File: tb/tb_wishbone_bus_if.sv
// Directed bench for wishbone_bus_if: the stimulus pushes expected bus
// completions into a scoreboard queue, a negedge monitor pops and compares.
module tb_wishbone_bus_if;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_ce_i, cpu_we_i;
    logic [31:0] cpu_addr_i, cpu_data_i, cpu_data_o;
    logic [3:0]  cpu_sel_i;
    logic [5:0]  stall_i;
    logic        flush_i, stallreq_o, err_o;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic        wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i;
    logic [3:0]  wb_sel_o;

    always #5 clk = ~clk;

    wishbone_bus_if #(.TIMEOUT_CYCLES(4), .STALL_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_ce_i   (cpu_ce_i),
        .cpu_we_i   (cpu_we_i),
        .cpu_addr_i (cpu_addr_i),
        .cpu_sel_i  (cpu_sel_i),
        .cpu_data_i (cpu_data_i),
        .cpu_data_o (cpu_data_o),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .stallreq_o (stallreq_o),
        .err_o      (err_o),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_dat_i   (wb_dat_i),
        .wb_we_o    (wb_we_o),
        .wb_sel_o   (wb_sel_o),
        .wb_stb_o   (wb_stb_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_ack_i   (wb_ack_i)
    );

    typedef struct {
        bit          is_err;
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] wdat;
        logic [31:0] rdat;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] model_rd_buf = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // One core access; slave acks in BUSY cycle ack_after; stall_i stays
    // nonzero for the ack cycle plus stall_more further cycles.
    task automatic access(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                          input logic [31:0] wdata, input int ack_after,
                          input logic [31:0] rdata, input int stall_more);
        exp_t e;
        tick();
        cpu_ce_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr;
        cpu_sel_i = sel; cpu_data_i = wdata; stall_i = '0;
        e = '{is_err: 1'b0, we: we, adr: addr, sel: sel, wdat: wdata, rdat: rdata};
        sb_q.push_back(e);
        sample();
        check("idle_stallreq", stallreq_o, 1'b1);
        check("idle_no_cyc", wb_cyc_o, 1'b0);
        for (int i = 1; i <= ack_after; i++) begin
            tick();
            if (i == ack_after) begin
                wb_ack_i = 1'b1;
                wb_dat_i = rdata;
                stall_i  = (stall_more > 0) ? 6'b000111 : 6'b0;
            end
            sample();
            check("busy_cyc", wb_cyc_o, 1'b1);
            check("busy_stb", wb_stb_o, 1'b1);
            if (i < ack_after) begin
                check("busy_stallreq", stallreq_o, 1'b1);
                check("busy_data_zero", cpu_data_o, 32'h0);
            end
        end
        if (!we) model_rd_buf = rdata;
        for (int j = 1; j <= stall_more + 1 && stall_more > 0; j++) begin
            tick();
            wb_ack_i = 1'b0; cpu_ce_i = 1'b0;
            stall_i  = (j <= stall_more) ? 6'b000111 : 6'b0;
            sample();
            check("wait_data", cpu_data_o, model_rd_buf);
            check("wait_stallreq", stallreq_o, 1'b0);
            check("wait_no_cyc", wb_cyc_o, 1'b0);
        end
        tick();
        wb_ack_i = 1'b0; cpu_ce_i = 1'b0; stall_i = '0;
        sample();
        check("done_cyc", wb_cyc_o, 1'b0);
        check("done_stallreq", stallreq_o, 1'b0);
        check("done_data", cpu_data_o, 32'h0);
    endtask

    // Scoreboard monitor: pops on every accepted ack and on every error pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (wb_cyc_o && wb_ack_i && !flush_i) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_ack", 32'd1, 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("ack_kind", {31'b0, mon_e.is_err}, 32'd0);
                    check("ack_cpu_data", cpu_data_o, mon_e.we ? 32'h0 : mon_e.rdat);
                    check("ack_stallreq", stallreq_o, 1'b0);
                    check("ack_adr", wb_adr_o, mon_e.adr);
                    check("ack_we", wb_we_o, mon_e.we);
                    check("ack_sel", wb_sel_o, mon_e.sel);
                    if (mon_e.we) check("ack_wdat", wb_dat_o, mon_e.wdat);
                end
            end
            if (err_o) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_err", 32'd1, 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("err_kind", {31'b0, mon_e.is_err}, 32'd1);
                    check("err_cyc_dropped", wb_cyc_o, 1'b0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        rst = 1'b1; cpu_ce_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0;
        cpu_sel_i = '0; cpu_data_i = '0; stall_i = '0; flush_i = 1'b0;
        wb_dat_i = '0; wb_ack_i = 1'b0;
        tick();
        tick();
        sample();
        check("rst_cyc", wb_cyc_o, 1'b0);
        check("rst_stb", wb_stb_o, 1'b0);
        check("rst_adr", wb_adr_o, 32'h0);
        check("rst_dat", wb_dat_o, 32'h0);
        check("rst_sel", wb_sel_o, 4'h0);
        check("rst_err", err_o, 1'b0);
        check("rst_stallreq", stallreq_o, 1'b0);
        tick();
        rst = 1'b0;

        // Read with ack in the third BUSY cycle.
        access(1'b0, 32'h0000_0040, 4'hF, 32'h0, 3, 32'hDEAD_BEEF, 0);
        // Write with ack in the first BUSY cycle.
        access(1'b1, 32'h0000_0100, 4'h3, 32'h1234_5678, 1, 32'h0BAD_F00D, 0);
        // Read held in WAIT_FOR_STALL by an external stall.
        access(1'b0, 32'h0000_0080, 4'hF, 32'h0, 1, 32'hA5A5_A5A5, 2);

        // Flush together with ack: no data delivered, buffer cleared.
        tick();
        cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h200; cpu_sel_i = 4'hF;
        sample();
        check("fl_idle_stallreq", stallreq_o, 1'b1);
        tick();
        wb_ack_i = 1'b1; flush_i = 1'b1; wb_dat_i = 32'hFFFF_FFFF;
        sample();
        check("fl_busy_cyc", wb_cyc_o, 1'b1);
        tick();
        wb_ack_i = 1'b0; flush_i = 1'b0; cpu_ce_i = 1'b0;
        model_rd_buf = 32'h0;
        sample();
        check("fl_cyc_drop", wb_cyc_o, 1'b0);
        check("fl_stb_drop", wb_stb_o, 1'b0);
        check("fl_data", cpu_data_o, 32'h0);
        // A write does not touch rd_buf, so its stall window exposes the flushed buffer.
        access(1'b1, 32'h0000_0104, 4'hC, 32'hCAFE_0001, 2, 32'h1111_1111, 1);

        // Flush in IDLE with a request pending starts nothing.
        tick();
        cpu_ce_i = 1'b1; flush_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h280;
        sample();
        check("fl_idle_no_req", stallreq_o, 1'b0);
        tick();
        sample();
        check("fl_idle_no_cyc", wb_cyc_o, 1'b0);
        tick();
        cpu_ce_i = 1'b0; flush_i = 1'b0;

        // Timeout: slave never acks.
        tick();
        cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h300; cpu_sel_i = 4'hF;
        e = '{is_err: 1'b1, we: 1'b0, adr: 32'h300, sel: 4'hF, wdat: 32'h0, rdat: 32'h0};
        sb_q.push_back(e);
        sample();
        for (int i = 1; i <= 4; i++) begin
            tick();
            sample();
            check("to_stb_held", wb_stb_o, 1'b1);
            check("to_err_low", err_o, 1'b0);
            if (i < 4) check("to_stallreq", stallreq_o, 1'b1);
            else begin
                check("to_release", stallreq_o, 1'b0);
                check("to_data", cpu_data_o, 32'h0);
            end
        end
        tick();
        cpu_ce_i = 1'b0;
        sample();
        check("to_err_pulse", err_o, 1'b1);
        check("to_cyc_drop", wb_cyc_o, 1'b0);
        check("to_stallreq_off", stallreq_o, 1'b0);
        tick();
        sample();
        check("to_err_once", err_o, 1'b0);

        // Reset during BUSY.
        tick();
        cpu_ce_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'h400; cpu_sel_i = 4'hF;
        cpu_data_i = 32'h5555_AAAA;
        tick();
        sample();
        check("rb_busy", wb_cyc_o, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; cpu_ce_i = 1'b0;
        sample();
        check("rb_cyc", wb_cyc_o, 1'b0);
        check("rb_stb", wb_stb_o, 1'b0);
        check("rb_we", wb_we_o, 1'b0);
        check("rb_adr", wb_adr_o, 32'h0);
        check("rb_stallreq", stallreq_o, 1'b0);

        check("sb_empty", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
